// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Bundles the two handshakes of the fetch stage:
//   - instruction memory read: imem_req/imem_addr out, imem_ready/imem_rdata in
//   - decode hand-off: instruction/instr_valid/pc/pc_plus4 out, instr_ready in
// Modports:
//   master - the fetch unit (drives requests and the held instruction)
//   slave  - memory plus decoder side (drives ready and read data)
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  modport master (
    output imem_req, imem_addr, instruction, instr_valid, pc, pc_plus4,
    input  imem_ready, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instruction, instr_valid, pc, pc_plus4,
    output imem_ready, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage. Owns the PC, issues one word read per instruction
// to instruction memory, holds the returned word for decode and computes the
// next PC from redirect information presented on the accept cycle.
// Ports:
//   clk, rst_n        - rising-edge clock, asynchronous active-low reset
//   bus (master)      - imem read handshake and decode valid/ready handshake
//   is_jump_reg       - register-target redirect, target = reg_target
//   is_jump           - J-type redirect, target = {pc_plus4[31:28], addr26, 00}
//   is_branch, branch_taken, imm16 - conditional branch, word offset from pc_plus4
//   instr_count       - number of instructions accepted since reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus,
  input  logic          is_jump,
  input  logic          is_jump_reg,
  input  logic [31:0]   reg_target,
  input  logic          is_branch,
  input  logic          branch_taken,
  input  logic [25:0]   addr26,
  input  logic [15:0]   imm16,
  output logic [31:0]   instr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      state;
  logic        imem_req_q;
  logic        instr_valid_q;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] instruction_q;
  logic [31:0] count_q;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect priority: register jump, then J-type, then taken branch.
  // NOTE: every always_comb output is assigned on every path so no latch
  // is inferred.
  always_comb begin
    branch_off = {{14{imm16[15]}}, imm16, 2'b00};
    next_pc    = pc_plus4;
    if (is_jump_reg)
      next_pc = {reg_target[31:2], 2'b00};
    else if (is_jump)
      next_pc = {pc_plus4[31:28], addr26, 2'b00};
    else if (is_branch && branch_taken)
      next_pc = pc_plus4 + branch_off;
  end

  // imem_req/instr_valid are registered alongside the state so they decode
  // from state only and are never high together. Ready inputs are only
  // looked at in the state that owns them, which makes stray ready pulses
  // and redirect inputs outside the accept cycle harmless.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      pc_q          <= RESET_PC;
      instruction_q <= 32'h0000_0000;
      count_q       <= 32'h0000_0000;
    end else begin
      case (state)
        S_IDLE: begin
          state      <= S_FETCH;
          imem_req_q <= 1'b1;
        end
        S_FETCH: begin
          if (bus.imem_ready) begin
            state         <= S_VALID;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
            instruction_q <= bus.imem_rdata;
          end
        end
        S_VALID: begin
          if (bus.instr_ready) begin
            state         <= S_FETCH;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            pc_q          <= next_pc;
            count_q       <= count_q + 32'd1;
          end
        end
        default: begin
          state         <= S_IDLE;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instruction = instruction_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign instr_count     = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed bench for fetch_unit: sequential fetch, wait states, consumer
// stall, branches, jumps, wrap-around and asynchronous reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_jump = 1'b0;
  logic        is_jump_reg = 1'b0;
  logic [31:0] reg_target = '0;
  logic        is_branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic [25:0] addr26 = '0;
  logic [15:0] imm16 = '0;
  logic [31:0] instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.master),
    .is_jump      (is_jump),
    .is_jump_reg  (is_jump_reg),
    .reg_target   (reg_target),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .addr26       (addr26),
    .imm16        (imm16),
    .instr_count  (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic clear_redirect();
    is_jump = 1'b0; is_jump_reg = 1'b0; reg_target = '0;
    is_branch = 1'b0; branch_taken = 1'b0; addr26 = '0; imm16 = '0;
  endtask

  // In S_FETCH at exp_addr: hold imem_ready low for waits cycles, then
  // return mem_word(exp_addr) and check the held instruction.
  task automatic fetch_one(input logic [31:0] exp_addr, input int waits);
    logic [31:0] exp_p4;
    exp_p4 = exp_addr + 32'd4;
    check("req_high", {31'd0, bus.imem_req}, 32'd1);
    check("imem_addr", bus.imem_addr, exp_addr);
    for (int i = 0; i < waits; i++) begin
      tick();
      check("req_wait", {31'd0, bus.imem_req}, 32'd1);
      check("addr_wait", bus.imem_addr, exp_addr);
    end
    bus.imem_ready = 1'b1;
    bus.imem_rdata = mem_word(exp_addr);
    tick();
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    check("valid_high", {31'd0, bus.instr_valid}, 32'd1);
    check("req_low", {31'd0, bus.imem_req}, 32'd0);
    check("instruction", bus.instruction, mem_word(exp_addr));
    check("pc", bus.pc, exp_addr);
    check("pc_plus4", bus.pc_plus4, exp_p4);
  endtask

  // In S_VALID: stall for stalls cycles while poking ignored inputs, then
  // accept with the redirect inputs already set by the caller.
  task automatic accept(input int stalls, input logic [31:0] held_addr,
                        input logic [31:0] exp_next, input logic [31:0] exp_count);
    logic        s_jr, s_j, s_b, s_t;
    logic [31:0] s_rt;
    s_jr = is_jump_reg; s_j = is_jump; s_b = is_branch; s_t = branch_taken;
    s_rt = reg_target;
    for (int i = 0; i < stalls; i++) begin
      bus.instr_ready = 1'b0;
      is_jump_reg = 1'b1; reg_target = 32'h0BAD_0000;
      bus.imem_ready = 1'b1; bus.imem_rdata = 32'h5555_AAAA;
      tick();
      check("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("stall_instr", bus.instruction, mem_word(held_addr));
      check("stall_pc", bus.pc, held_addr);
      check("stall_count", instr_count, exp_count - 32'd1);
    end
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'h0;
    is_jump_reg = s_jr; is_jump = s_j; is_branch = s_b; branch_taken = s_t;
    reg_target = s_rt;
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    clear_redirect();
    check("acc_req", {31'd0, bus.imem_req}, 32'd1);
    check("acc_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("next_addr", bus.imem_addr, exp_next);
    check("count", instr_count, exp_count);
  endtask

  initial begin
    bus.imem_ready  = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;
    tick();
    tick();
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_pc_plus4", bus.pc_plus4, 32'h4);
    check("rst_instr", bus.instruction, 32'h0);
    check("rst_count", instr_count, 32'h0);
    rst_n = 1'b1;
    tick();  // first edge after reset release: S_FETCH

    // Sequential fetch, wait states and stall.
    fetch_one(32'h0, 0);
    accept(0, 32'h0, 32'h4, 32'd1);
    fetch_one(32'h4, 3);
    accept(4, 32'h4, 32'h8, 32'd2);
    fetch_one(32'h8, 0);
    accept(0, 32'h8, 32'hC, 32'd3);
    fetch_one(32'hC, 0);
    accept(0, 32'hC, 32'h10, 32'd4);

    // Taken branch with offset -1 word, then not-taken.
    fetch_one(32'h10, 0);
    is_branch = 1'b1; branch_taken = 1'b1; imm16 = 16'hFFFF;
    accept(0, 32'h10, 32'h10, 32'd5);
    fetch_one(32'h10, 0);
    is_branch = 1'b1; branch_taken = 1'b0; imm16 = 16'hFFFF;
    accept(0, 32'h10, 32'h14, 32'd6);

    // Register jump drops low bits; J-type jump; priority.
    fetch_one(32'h14, 0);
    is_jump_reg = 1'b1; reg_target = 32'h1000_0043;
    accept(0, 32'h14, 32'h1000_0040, 32'd7);
    fetch_one(32'h1000_0040, 0);
    is_jump = 1'b1; addr26 = 26'h0000100;
    accept(0, 32'h1000_0040, 32'h1000_0400, 32'd8);
    fetch_one(32'h1000_0400, 0);
    is_jump_reg = 1'b1; is_jump = 1'b1; reg_target = 32'h0000_2003;
    addr26 = 26'h3FF_FFFF;
    accept(0, 32'h1000_0400, 32'h0000_2000, 32'd9);

    // PC wrap-around.
    fetch_one(32'h2000, 0);
    is_jump_reg = 1'b1; reg_target = 32'hFFFF_FFFC;
    accept(0, 32'h2000, 32'hFFFF_FFFC, 32'd10);
    fetch_one(32'hFFFF_FFFC, 0);
    accept(0, 32'hFFFF_FFFC, 32'h0, 32'd11);

    // instr_ready during S_FETCH is ignored.
    bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    check("fetch_ready_ign_count", instr_count, 32'd11);
    check("fetch_ready_ign_req", {31'd0, bus.imem_req}, 32'd1);
    fetch_one(32'h0, 0);
    accept(0, 32'h0, 32'h4, 32'd12);

    // Asynchronous reset mid-fetch.
    #2 rst_n = 1'b0;
    #1;
    check("arst_fetch_req", {31'd0, bus.imem_req}, 32'd0);
    check("arst_fetch_pc", bus.pc, 32'h0);
    check("arst_fetch_count", instr_count, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch_one(32'h0, 1);

    // Asynchronous reset mid-hold.
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("arst_instr", bus.instruction, 32'h0);
    check("arst_count", instr_count, 32'h0);
    check("arst_req", {31'd0, bus.imem_req}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
